// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a framed image, writes it into instruction
// memory and releases the core once the XOR checksum matches.
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              im_wren,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_data,
  output logic              core_hold,
  output logic              core_enable,
  output logic              done,
  output logic              err
);

  // Word count must hold 2^ADDR_W as well as any raw 8-bit header value.
  localparam int IW = ADDR_W + 1;
  localparam int NW = (IW > 9) ? IW : 9;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_HDR, DATA, WRITE, CSUM, RUN, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [7:0]        acc_q, acc_d;
  logic [31:0]       asm_q, asm_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              rdy_q, wren_q, run_q, err_q;
  logic              xfer;

  assign xfer = rx_valid & rx_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bidx_d  = bidx_q;
    acc_d   = acc_q;
    asm_d   = asm_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      WAIT_HDR: begin
        if (xfer) begin
          n_d     = (rx_byte == 8'd0) ? (NW'(1) << ADDR_W) : NW'(rx_byte);
          acc_d   = rx_byte;
          idx_d   = '0;
          bidx_d  = '0;
          tmr_d   = TMR_LOAD;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          asm_d  = {asm_q[23:0], rx_byte};
          acc_d  = acc_q ^ rx_byte;
          tmr_d  = TMR_LOAD;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            addr_d  = idx_q[ADDR_W-1:0];
            data_d  = {asm_q[23:0], rx_byte};
            state_d = WRITE;
          end
        end else if (tmr_q == '0) begin
          state_d = ERROR;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      WRITE: begin
        idx_d   = idx_q + IW'(1);
        state_d = (NW'(idx_q) + NW'(1) == n_q) ? CSUM : DATA;
      end
      CSUM: begin
        if (xfer) begin
          state_d = (rx_byte == acc_q) ? RUN : ERROR;
        end else if (tmr_q == '0) begin
          state_d = ERROR;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      RUN, ERROR: begin
        if (load_req) begin
          idx_d   = '0;
          bidx_d  = '0;
          tmr_d   = '0;
          state_d = WAIT_HDR;
        end
      end
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_HDR;
      n_q     <= '0;
      idx_q   <= '0;
      bidx_q  <= '0;
      acc_q   <= '0;
      asm_q   <= '0;
      tmr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b1;
      wren_q  <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bidx_q  <= bidx_d;
      acc_q   <= acc_d;
      asm_q   <= asm_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdy_q   <= (state_d == WAIT_HDR) || (state_d == DATA) || (state_d == CSUM);
      wren_q  <= (state_d == WRITE);
      run_q   <= (state_d == RUN);
      err_q   <= (state_d == ERROR);
    end
  end

  // rdy_q already reflects WAIT_HDR during reset; gating keeps the stream stalled until release.
  assign rx_ready    = rdy_q & ~rst;
  assign im_wren     = wren_q;
  assign im_addr     = addr_q;
  assign im_data     = data_q;
  assign core_hold   = ~run_q;
  assign core_enable = run_q;
  assign done        = run_q;
  assign err         = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as frames
// are driven and checked against every im_wren observed.
module tb_prog_loader;
  localparam int AW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          load_req = 1'b0;
  logic          rx_ready, im_wren, core_hold, core_enable, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_data;
  logic [4:0]    st;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  typedef logic [31:0] wq_t[$];
  wr_t sb[$];

  prog_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .load_req(load_req), .im_wren(im_wren), .im_addr(im_addr), .im_data(im_data),
    .core_hold(core_hold), .core_enable(core_enable), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // status order: done, core_enable, core_hold, err, rx_ready
  assign st = {done, core_enable, core_hold, err, rx_ready};

  always @(negedge clk) begin
    wr_t e;
    if (im_wren === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", im_addr, im_data);
      end else begin
        e = sb.pop_front();
        if ({im_addr, im_data} !== e) begin
          errors++;
          $display("FAIL write_content: addr=%0d data=%h, required addr=%0d data=%h",
                   im_addr, im_data, e.addr, e.data);
        end
      end
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write: rx_ready=%b, required 0", rx_ready);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n;
    rx_valid = 1'b1;
    rx_byte  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL byte_accept_timeout: rx_ready=%b for byte %h, required 1 within 100 cycles", rx_ready, b);
    end
    @(negedge clk);
    if (!hold) rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input wq_t w, input bit bad, input bit hold);
    logic [7:0] cs;
    wr_t e;
    cs = hdr;
    send_byte(hdr, hold);
    foreach (w[i]) begin
      e.addr = i[AW-1:0];
      e.data = w[i];
      sb.push_back(e);
      for (int k = 3; k >= 0; k--) begin
        cs ^= w[i][8*k +: 8];
        send_byte(w[i][8*k +: 8], hold);
      end
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, 1'b0);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (st !== 5'b00100 || im_wren !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: status=%b wren=%b, required status=00100 wren=0", st, im_wren);
    end
    checks++;
    if (im_addr !== '0 || im_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_bus: addr=%0d data=%h, required 0/0", im_addr, im_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: rx_ready=%b, required 1", rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_good();
    wr_t e;
    e.addr = '0;
    e.data = 32'h20010005;
    sb.push_back(e);
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    checks++;
    if (im_wren !== 1'b1) begin
      errors++;
      $display("FAIL write_latency: im_wren=%b one cycle after byte 5, required 1", im_wren);
    end
    send_byte(8'h25, 1'b0);
    checks++;
    if (st !== 5'b11000) begin
      errors++;
      $display("FAIL good_run: status=%b, required 11000", st);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL good_writes: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_bad_csum();
    pulse_load();
    send_frame(8'h01, '{32'h20010005}, 1'b1, 1'b0);
    checks++;
    if (st !== 5'b00110) begin
      errors++;
      $display("FAIL bad_csum_error: status=%b, required 00110", st);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bad_csum_writes: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    pulse_load();
    send_frame(8'h02, '{32'hDEADBEEF, 32'h01234567}, 1'b0, 1'b1);
    checks++;
    if (st !== 5'b11000) begin
      errors++;
      $display("FAIL backpressure_run: status=%b, required 11000", st);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL backpressure_writes: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_timeout();
    pulse_load();
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (st !== 5'b00101) begin
      errors++;
      $display("FAIL timeout_early: status=%b after %0d idle, required 00101", st, TO - 1);
    end
    @(negedge clk);
    checks++;
    if (st !== 5'b00110) begin
      errors++;
      $display("FAIL timeout_error: status=%b after %0d idle, required 00110", st, TO);
    end
  endtask

  task automatic test_reload();
    wr_t e;
    pulse_load();
    checks++;
    if (st !== 5'b00101) begin
      errors++;
      $display("FAIL reload_from_error: status=%b, required 00101", st);
    end
    // load_req mid-DATA must be ignored
    e.addr = '0;
    e.data = 32'h11223344;
    sb.push_back(e);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_load();
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b0);
    checks++;
    if (st !== 5'b11000) begin
      errors++;
      $display("FAIL load_ignored_in_data: status=%b, required 11000", st);
    end
    pulse_load();
    checks++;
    if (st !== 5'b00101) begin
      errors++;
      $display("FAIL reload_from_run: status=%b, required 00101", st);
    end
    send_frame(8'h01, '{32'hCAFEF00D}, 1'b0, 1'b0);
    checks++;
    if (st !== 5'b11000 || sb.size() != 0) begin
      errors++;
      $display("FAIL reload_frame: status=%b pending=%0d, required 11000 and 0", st, sb.size());
    end
  endtask

  task automatic test_hdr_zero();
    wr_t e;
    pulse_load();
    send_frame(8'h00, '{32'h00000001, 32'hA5A5A5A5, 32'h12345678, 32'hFFFF0000}, 1'b0, 1'b0);
    checks++;
    if (st !== 5'b11000 || sb.size() != 0) begin
      errors++;
      $display("FAIL hdr_zero_run: status=%b pending=%0d, required 11000 and 0", st, sb.size());
    end
    pulse_load();
    for (int i = 0; i < 2; i++) begin
      e.addr = i[AW-1:0];
      e.data = 32'h01010101 * (i + 1);
      sb.push_back(e);
    end
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) send_byte(8'(i + 1), 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h77, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (st !== 5'b00100 || im_wren !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_reset: status=%b wren=%b, required 00100 and 0", st, im_wren);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_mid_reset: rx_ready=%b, required 1", rx_ready);
    end
    @(negedge clk);
    send_frame(8'h01, '{32'h0BADF00D}, 1'b0, 1'b0);
    checks++;
    if (st !== 5'b11000 || sb.size() != 0) begin
      errors++;
      $display("FAIL frame_after_reset: status=%b pending=%0d, required 11000 and 0", st, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_backpressure();
    test_timeout();
    test_reload();
    test_hdr_zero();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory word-address width (matches 8-bit PC).
REQ-002 Parameter: TIMEOUT, default 1000, maximum idle cycles allowed between bytes once a load has started.
REQ-003 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: rx_valid  input  1  byte-stream source has a byte on rx_byte.
REQ-006 Port: rx_byte  input  8  incoming load byte.
REQ-007 Port: rx_ready  output  1  loader accepts rx_byte this cycle; a transfer occurs when rx_valid & rx_ready.
REQ-008 Port: load_req  input  1  one-cycle pulse requesting a fresh load from RUN or ERROR.
REQ-009 Port: im_wren  output  1  instruction-memory write strobe.
REQ-010 Port: im_addr  output  ADDR_W  instruction-memory word address.
REQ-011 Port: im_data  output  32  instruction word to write.
REQ-012 Port: core_hold  output  1  high holds the processor core in reset.
REQ-013 Port: core_enable  output  1  drives the processor pipeline enable.
REQ-014 Port: done  output  1  high while in RUN.
REQ-015 Port: err  output  1  high while in ERROR.

Function
REQ-016 Frame format SHALL be: 1 header byte N (word count, 0 encodes 2^ADDR_W), then N words of 4 bytes each, most significant byte first, then 1 checksum byte.
REQ-017 Checksum SHALL be the XOR of the header and all data bytes; the frame is good when the received checksum equals it.
REQ-018 States SHALL be WAIT_HDR, DATA, WRITE, CSUM, RUN, ERROR.
REQ-019 WAIT_HDR: rx_ready=1; on a transfer, latch N, set the XOR accumulator to the byte, clear the word index and byte index, and go to DATA.
REQ-020 DATA: rx_ready=1; each transfer shifts the byte into a 32-bit assembly register and XORs it into the accumulator; on the 4th byte go to WRITE.
REQ-021 WRITE: lasts exactly one cycle; rx_ready=0; im_wren=1, im_addr=word index, im_data=assembled word.
REQ-022 Leaving WRITE: increment the word index; go to CSUM if the word index equals N, otherwise go to DATA.
REQ-023 CSUM: rx_ready=1; on a transfer go to RUN on a checksum match, otherwise go to ERROR.
REQ-024 RUN: core_hold=0, core_enable=1, done=1, rx_ready=0.
REQ-025 ERROR: err=1, core_hold=1, core_enable=0, rx_ready=0.
REQ-026 load_req SHALL move RUN or ERROR to WAIT_HDR and clear all counters; load_req SHALL be ignored in every other state.
REQ-027 core_hold SHALL be 1 and core_enable SHALL be 0 in every state except RUN.
REQ-028 Timeout: in DATA and CSUM, count consecutive cycles without a transfer; on reaching TIMEOUT go to ERROR; any transfer clears the count.
REQ-029 WAIT_HDR SHALL never time out.
REQ-030 Word-index width SHALL be ADDR_W+1 so that N=2^ADDR_W completes without wrap-around; im_addr uses the low ADDR_W bits.
REQ-031 im_wren SHALL be 0 in every state except WRITE.
REQ-032 Bytes presented while rx_ready=0 SHALL NOT be consumed.

Reset
REQ-033 rst high SHALL force state WAIT_HDR and clear the XOR accumulator, all counters, the assembly register, im_addr and im_data.
REQ-034 While rst is high, outputs SHALL be: rx_ready=0, im_wren=0, core_hold=1, core_enable=0, done=0, err=0.
REQ-035 The first cycle after rst falls SHALL show rx_ready=1.
REQ-036 rst asserted mid-frame or during RUN SHALL abandon the frame, issue no further writes, and re-hold the core.

Verification
REQ-037 Good frame: bytes 01,20,01,00,05,25 -> a single im_wren with im_addr=0, im_data=0x20010005 one cycle after byte 5; RUN entered after byte 6; core_enable=1.
REQ-038 Bad checksum: the same frame with last byte 24 -> one write occurs, then ERROR; err=1, core_hold=1.
REQ-039 Backpressure: rx_valid held high continuously -> rx_ready=0 in each WRITE cycle and no byte lost; a 2-word frame yields writes at addresses 0 and 1.
REQ-040 Timeout (TIMEOUT=16): header 02, 3 data bytes, then 16 idle cycles -> ERROR, no im_wren issued.
REQ-041 Reload: in RUN, pulse load_req -> WAIT_HDR next cycle; core_hold=1; a new 1-word frame rewrites address 0.
REQ-042 Header 00 with ADDR_W=2 -> 4 writes at addresses 0..3, then CSUM; mid-frame rst -> WAIT_HDR and no further writes.
